// File: rtl/pte_mem_responder_if.sv
// Walker-side request/response and DRAM-side request/done bundle for the PTE responder.
// The master drives the i_* signals (page walker plus DRAM arbiter); the slave is the responder.
interface pte_mem_responder_if #(
  parameter int ADDR_W = 32
);
  // page walker side
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              i_flush;
  logic              o_busy;
  logic              o_rvalid;
  logic [31:0]       o_rdata;
  // DRAM arbiter side
  logic              o_dram_req;
  logic              o_dram_we;
  logic [ADDR_W-1:0] o_dram_addr;
  logic [31:0]       o_dram_wdata;
  logic              i_dram_done;
  logic [31:0]       i_dram_rdata;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_flush, i_dram_done, i_dram_rdata,
    input  o_busy, o_rvalid, o_rdata, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_flush, i_dram_done, i_dram_rdata,
    output o_busy, o_rvalid, o_rdata, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
  );
endinterface

// File: rtl/pte_mem_responder.sv
// PTE responder: direct-mapped write-through PTE cache in front of a one-outstanding DRAM port.
// Hits answer the cycle after the request; misses and write-backs go to DRAM.
module pte_mem_responder #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 32
) (
  input logic                CLK,
  input logic                RST,
  pte_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_t;

  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } cache_wr_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              dreq_q, dreq_d;
  logic              dwe_q, dwe_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [31:0]       dwdata_q, dwdata_d;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [31:0]       data_q [DEPTH];

  cache_wr_t         cwr;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [ADDR_W-1:0] word_addr;
  logic              hit;
  logic              unused_addr_lo;

  assign req_idx        = bus.i_addr[IDX_W+1:2];
  assign req_tag        = bus.i_addr[ADDR_W-1:IDX_W+2];
  assign word_addr      = {bus.i_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_lo = ^bus.i_addr[1:0];

  // A flush in the lookup cycle forces a miss even if the entry was valid.
  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !bus.i_flush;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    cwr      = '0;
    unique case (state_q)
      // RESP only marks the rvalid cycle; it accepts requests exactly like IDLE.
      IDLE, RESP: begin
        state_d = IDLE;
        if (bus.i_req) begin
          if (bus.i_we) begin
            cwr.en   = 1'b1;
            cwr.idx  = req_idx;
            cwr.tag  = req_tag;
            cwr.data = bus.i_wdata;
            busy_d   = 1'b1;
            dreq_d   = 1'b1;
            dwe_d    = 1'b1;
            daddr_d  = word_addr;
            dwdata_d = bus.i_wdata;
            state_d  = WR_MEM;
          end else if (hit) begin
            rdata_d  = data_q[req_idx];
            rvalid_d = 1'b1;
            state_d  = RESP;
          end else begin
            busy_d   = 1'b1;
            dreq_d   = 1'b1;
            dwe_d    = 1'b0;
            daddr_d  = word_addr;
            state_d  = RD_MEM;
          end
        end
      end
      RD_MEM: begin
        if (bus.i_dram_done) begin
          rdata_d  = bus.i_dram_rdata;
          cwr.en   = 1'b1;
          cwr.idx  = daddr_q[IDX_W+1:2];
          cwr.tag  = daddr_q[ADDR_W-1:IDX_W+2];
          cwr.data = bus.i_dram_rdata;
          dreq_d   = 1'b0;
          busy_d   = 1'b0;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end
      end
      WR_MEM: begin
        if (bus.i_dram_done) begin
          dreq_d   = 1'b0;
          busy_d   = 1'b0;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
    end
  end

  // Flush wins over any fill or write landing in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST || bus.i_flush) valid_q <= '0;
    else if (cwr.en)        valid_q[cwr.idx] <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (cwr.en && !bus.i_flush) begin
      tag_q[cwr.idx]  <= cwr.tag;
      data_q[cwr.idx] <= cwr.data;
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_rvalid     = rvalid_q;
  assign bus.o_rdata      = rdata_q;
  assign bus.o_dram_req   = dreq_q;
  assign bus.o_dram_we    = dwe_q;
  assign bus.o_dram_addr  = daddr_q;
  assign bus.o_dram_wdata = dwdata_q;
endmodule

// File: tb/tb_pte_mem_responder.sv
// Directed bench for pte_mem_responder: a transaction table with a small DRAM model,
// followed by hand-written back-to-back, stray-done and reset-abort sequences.
module tb_pte_mem_responder;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 CLK = ~CLK;

  pte_mem_responder_if #(.ADDR_W(32)) bus ();

  pte_mem_responder #(.IDX_W(3), .ADDR_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // lat == 0 means a cache hit is expected (no DRAM traffic)
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        fl_done;
    int          lat;
    logic [31:0] drd;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic do_txn(input vec_t v, input int id);
    int          c, dreq_cnt, busy_cnt, rv_c;
    logic        got, busy_rv, d_we;
    logic [31:0] rd, d_addr, d_wdata;
    string       tg;
    tg = $sformatf("t%0d", id);
    @(negedge CLK);
    bus.i_req   = 1'b1;
    bus.i_we    = v.we;
    bus.i_addr  = v.addr;
    bus.i_wdata = v.wdata;
    bus.i_flush = v.flush;
    @(negedge CLK);
    bus.i_req   = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_flush = 1'b0;
    c = 0; dreq_cnt = 0; busy_cnt = 0; rv_c = -1; got = 1'b0;
    busy_rv = 1'b0; d_we = 1'b0; rd = '0; d_addr = '0; d_wdata = '0;
    while (!got && c < 40) begin
      if (bus.o_rvalid) begin
        got = 1'b1; rv_c = c; rd = bus.o_rdata; busy_rv = bus.o_busy;
      end else begin
        if (bus.o_busy) busy_cnt++;
        if (bus.o_dram_req) begin
          dreq_cnt++;
          d_addr = bus.o_dram_addr; d_we = bus.o_dram_we; d_wdata = bus.o_dram_wdata;
        end
        bus.i_dram_done  = bus.o_dram_req && (dreq_cnt == v.lat);
        bus.i_flush      = bus.i_dram_done && v.fl_done;
        bus.i_dram_rdata = v.drd;
        @(negedge CLK);
        c++;
      end
    end
    bus.i_dram_done = 1'b0;
    bus.i_flush     = 1'b0;
    chk({tg, " rvalid_seen"}, 32'(got), 32'd1);
    chk({tg, " latency"}, 32'(rv_c), 32'(v.lat));
    chk({tg, " dram_req_cycles"}, 32'(dreq_cnt), 32'(v.lat));
    chk({tg, " busy_cycles"}, 32'(busy_cnt), 32'(v.lat));
    chk({tg, " busy_at_rvalid"}, 32'(busy_rv), 32'd0);
    chk({tg, " rdata"}, rd, v.exp_rdata);
    if (v.lat > 0) begin
      chk({tg, " dram_addr"}, d_addr, v.addr & 32'hFFFF_FFFC);
      chk({tg, " dram_we"}, 32'(d_we), 32'(v.we));
      if (v.we) chk({tg, " dram_wdata"}, d_wdata, v.wdata);
    end
    @(negedge CLK);
    chk({tg, " rvalid_single"}, 32'(bus.o_rvalid), 32'd0);
  endtask

  vec_t tbl[18];

  initial begin
    vec_t v;
    int   rv_seen;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_flush = 1'b0; bus.i_dram_done = 1'b0; bus.i_dram_rdata = '0;

    //           we  addr          wdata         fl  fd  lat drd           exp
    tbl[0]  = '{1'b0, 32'h8000_1004, 32'h0,         1'b0, 1'b0, 3, 32'h2000_0C01, 32'h2000_0C01};
    tbl[1]  = '{1'b0, 32'h8000_1004, 32'h0,         1'b0, 1'b0, 0, 32'h0,         32'h2000_0C01};
    tbl[2]  = '{1'b1, 32'h8000_1004, 32'h2000_0CC1, 1'b0, 1'b0, 2, 32'h0,         32'h2000_0C01};
    tbl[3]  = '{1'b0, 32'h8000_1004, 32'h0,         1'b0, 1'b0, 0, 32'h0,         32'h2000_0CC1};
    tbl[4]  = '{1'b0, 32'h8000_1006, 32'h0,         1'b0, 1'b0, 0, 32'h0,         32'h2000_0CC1};
    tbl[5]  = '{1'b0, 32'h8000_1024, 32'h0,         1'b0, 1'b0, 1, 32'h1111_1111, 32'h1111_1111};
    tbl[6]  = '{1'b0, 32'h8000_1004, 32'h0,         1'b0, 1'b0, 2, 32'h2222_2222, 32'h2222_2222};
    tbl[7]  = '{1'b0, 32'h8000_1024, 32'h0,         1'b0, 1'b0, 1, 32'h3333_3333, 32'h3333_3333};
    tbl[8]  = '{1'b0, 32'h8000_1024, 32'h0,         1'b1, 1'b0, 2, 32'h4444_4444, 32'h4444_4444};
    tbl[9]  = '{1'b0, 32'h8000_1024, 32'h0,         1'b0, 1'b0, 0, 32'h0,         32'h4444_4444};
    tbl[10] = '{1'b0, 32'h8000_2003, 32'h0,         1'b0, 1'b0, 1, 32'h0000_0055, 32'h0000_0055};
    tbl[11] = '{1'b0, 32'h8000_2000, 32'h0,         1'b0, 1'b0, 0, 32'h0,         32'h0000_0055};
    tbl[12] = '{1'b1, 32'h8000_3008, 32'h0000_0066, 1'b1, 1'b0, 1, 32'h0,         32'h0000_0055};
    tbl[13] = '{1'b0, 32'h8000_3008, 32'h0,         1'b0, 1'b0, 1, 32'h0000_0077, 32'h0000_0077};
    tbl[14] = '{1'b0, 32'h8000_2000, 32'h0,         1'b0, 1'b0, 1, 32'h0000_0088, 32'h0000_0088};
    tbl[15] = '{1'b0, 32'h8000_4010, 32'h0,         1'b0, 1'b1, 1, 32'h0000_0099, 32'h0000_0099};
    tbl[16] = '{1'b0, 32'h8000_4010, 32'h0,         1'b0, 1'b0, 1, 32'h0000_00AA, 32'h0000_00AA};
    tbl[17] = '{1'b0, 32'h8000_4010, 32'h0,         1'b0, 1'b0, 0, 32'h0,         32'h0000_00AA};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst busy", 32'(bus.o_busy), 32'd0);
    chk("rst rvalid", 32'(bus.o_rvalid), 32'd0);
    chk("rst rdata", bus.o_rdata, 32'h0);
    chk("rst dram_req", 32'(bus.o_dram_req), 32'd0);
    chk("rst dram_we", 32'(bus.o_dram_we), 32'd0);
    chk("rst dram_addr", bus.o_dram_addr, 32'h0);
    chk("rst dram_wdata", bus.o_dram_wdata, 32'h0);

    for (int i = 0; i < 18; i++) do_txn(tbl[i], i);

    // stray done with no DRAM request outstanding
    @(negedge CLK);
    bus.i_dram_done = 1'b1; bus.i_dram_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    bus.i_dram_done = 1'b0;
    chk("stray_done rvalid", 32'(bus.o_rvalid), 32'd0);
    chk("stray_done rdata", bus.o_rdata, 32'h0000_00AA);
    chk("stray_done busy", 32'(bus.o_busy), 32'd0);

    // fill index 0 so the back-to-back run alternates between two entries
    v = '{1'b0, 32'h8000_5000, 32'h0, 1'b0, 1'b0, 1, 32'h0000_00BB, 32'h0000_00BB};
    do_txn(v, 100);

    @(negedge CLK);
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'h8000_4010;
    @(negedge CLK);
    bus.i_addr = 32'h8000_5000;
    chk("b2b0 rvalid", 32'(bus.o_rvalid), 32'd1);
    chk("b2b0 rdata", bus.o_rdata, 32'h0000_00AA);
    @(negedge CLK);
    bus.i_addr = 32'h8000_4010;
    chk("b2b1 rvalid", 32'(bus.o_rvalid), 32'd1);
    chk("b2b1 rdata", bus.o_rdata, 32'h0000_00BB);
    chk("b2b1 busy", 32'(bus.o_busy), 32'd0);
    @(negedge CLK);
    bus.i_req = 1'b0;
    chk("b2b2 rvalid", 32'(bus.o_rvalid), 32'd1);
    chk("b2b2 rdata", bus.o_rdata, 32'h0000_00AA);
    @(negedge CLK);
    chk("b2b end rvalid", 32'(bus.o_rvalid), 32'd0);

    // reset while a DRAM read is outstanding; a write request mid-miss must be ignored
    @(negedge CLK);
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'h8000_6004;
    @(negedge CLK);
    bus.i_we = 1'b1; bus.i_addr = 32'h8000_7000; bus.i_wdata = 32'h0000_0123;
    @(negedge CLK);
    bus.i_req = 1'b0; bus.i_we = 1'b0;
    chk("abort dram_req", 32'(bus.o_dram_req), 32'd1);
    chk("abort busy", 32'(bus.o_busy), 32'd1);
    chk("ignored req addr", bus.o_dram_addr, 32'h8000_6004);
    chk("ignored req we", 32'(bus.o_dram_we), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort dram_req after", 32'(bus.o_dram_req), 32'd0);
    chk("abort busy after", 32'(bus.o_busy), 32'd0);
    rv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.o_rvalid) rv_seen++;
      @(negedge CLK);
    end
    chk("abort no rvalid", 32'(rv_seen), 32'd0);
    v = '{1'b0, 32'h8000_4010, 32'h0, 1'b0, 1'b0, 1, 32'h0000_00CC, 32'h0000_00CC};
    do_txn(v, 101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pte_mem_responder.md
Name: pte_mem_responder

Overview:
- Memory-side responder for page-walk PTE traffic.
- Accepts single-word PTE read and A/D write-back requests from the MMU page walker and returns PTE data with a busy/valid handshake.
- Services requests from a small direct-mapped PTE cache, or from DRAM through a one-outstanding request/done interface.
- Sits between the MMU and the DRAM arbiter; flushed on sfence.vma, alongside the TLB flush.

Parameters:
- IDX_W, 3, log2 of PTE cache entries (8 entries by default).
- ADDR_W, 32, physical address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- i_req  in  1  one-cycle request strobe from the page walker; honoured only when o_busy=0.
- i_we  in  1  1 = PTE write-back, 0 = PTE read; sampled with i_req.
- i_addr  in  ADDR_W  PTE physical address; bits [1:0] ignored.
- i_wdata  in  32  PTE write data (already has A/D set).
- i_flush  in  1  invalidate all cache entries.
- o_busy  out  1  request in progress; new requests are ignored while high.
- o_rvalid  out  1  one-cycle pulse: o_rdata is valid, or the write has completed.
- o_rdata  out  32  read PTE; held until the next accepted read.
- o_dram_req  out  1  DRAM access request; held until i_dram_done.
- o_dram_we  out  1  DRAM write enable.
- o_dram_addr  out  ADDR_W  word-aligned address ({i_addr[ADDR_W-1:2],2'b00}).
- o_dram_wdata  out  32  DRAM write data.
- i_dram_done  in  1  DRAM access complete; read data is valid in the same cycle.
- i_dram_rdata  in  32  DRAM read data.

Behaviour:
- Reset values:
  - all outputs 0;
  - all valid bits 0;
  - state IDLE.
- Reset mid-operation drops o_dram_req the following cycle. No o_rvalid is produced for the aborted request.
- Cache organisation:
  - index = addr[IDX_W+1:2];
  - tag = addr[ADDR_W-1:IDX_W+2];
  - valid bit per entry.
- States: IDLE, RD_MEM, WR_MEM, RESP.
- IDLE, on i_req && !i_we:
  - Hit (valid && tag match): o_rdata <= entry data. State RESP; o_busy stays 0. o_rvalid pulses the next cycle, so latency is 1.
  - Miss: o_busy <= 1, o_dram_req <= 1, o_dram_we <= 0. Go to RD_MEM.
- IDLE, on i_req && i_we (write-through):
  - The cache entry at the index is written with tag/data and valid set, whether hit or miss (allocate-on-write).
  - o_busy <= 1, o_dram_req <= 1, o_dram_we <= 1. Go to WR_MEM.
- RD_MEM: waits for i_dram_done. On done:
  - o_rdata <= i_dram_rdata;
  - fill the entry (valid=1);
  - o_dram_req <= 0, o_busy <= 0, o_rvalid <= 1;
  - go to IDLE.
- WR_MEM: on i_dram_done:
  - o_dram_req <= 0, o_busy <= 0, o_rvalid <= 1;
  - go to IDLE.
- RESP: o_rvalid=1 for exactly one cycle, then IDLE. An i_req arriving in RESP is accepted as if in IDLE, so back-to-back hits produce one result per cycle.
- o_dram_addr, o_dram_we and o_dram_wdata are registered at acceptance and stable while o_dram_req=1.
- i_dram_done while o_dram_req=0 is ignored.
- i_req while o_busy=1 is ignored, with no state change.
- i_flush:
  - Clears all valid bits the same cycle, with priority over any fill or write in that cycle: a fill coinciding with flush is discarded, but o_rdata/o_rvalid still complete.
  - i_req coinciding with i_flush looks up the cache as invalid (forced miss).
  - Flush does not abort an in-flight DRAM access.
- Addresses differing only in bits [1:0] alias to the same entry.
- Index wrap: an index-conflicting fill replaces the old entry.

Test Plan:
- Reset, then read 0x8000_1004 (miss); DRAM done after 3 cycles with 0x2000_0C01 -> o_dram_req high 3 cycles with addr 0x8000_1004 and we=0; o_rvalid pulse with o_rdata=0x2000_0C01; o_busy low the same cycle.
- Repeat read 0x8000_1004 -> no o_dram_req; o_rvalid the next cycle with 0x2000_0C01; o_busy never high.
- Write 0x8000_1004 with 0x2000_0CC1 -> DRAM we=1, wdata=0x2000_0CC1; after done, a read of 0x8000_1004 hits and returns 0x2000_0CC1.
- Read 0x8000_1024 (same index with IDX_W=3, different tag) -> miss and fill; then a read of 0x8000_1004 misses again.
- Assert i_flush together with a read of a cached address -> DRAM read issued; a subsequent read is served from DRAM data, not the stale entry.
- Assert RST during RD_MEM -> o_dram_req=0, o_busy=0 the next cycle; no o_rvalid; all entries invalid, so the next read misses.
